transceiver_skp_inserter: RTL and testbench

//  TX-side clock-compensation source for the LVDS link; sits between the TX packet/framing logic and the 8b/10b encoder.

---
 rtl/transceiver_skp_inserter_pkg.sv | 16 +
 rtl/transceiver_skp_inserter_async_reset.sv | 23 ++
 rtl/transceiver_skp_inserter.sv | 118 +++++++++++
 tb/tb_transceiver_skp_inserter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/transceiver_skp_inserter_pkg.sv
// Shared constants and types for the TX SKP inserter.
//   SKP_SYMBOL  : K28.3 as a 9-bit {k_flag, byte} symbol
//   K_FLAG_BIT  : bit index of the k flag within a symbol
//   state_t     : inserter FSM states
package transceiver_skp_inserter_pkg;

    localparam int          SYMBOL_WIDTH = 9;
    localparam int          K_FLAG_BIT   = 8;
    localparam logic [8:0]  SKP_SYMBOL   = {1'b1, 8'h7c};

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_SKP  = 1'b1
    } state_t;

endpackage

// File: rtl/transceiver_skp_inserter_async_reset.sv
// Reset synchroniser: asserts asynchronously, releases synchronously.
//   clk    : destination clock
//   arst_n : raw asynchronous active-low reset
//   rst_n  : synchronised active-low reset (released after 2 clk edges)
module transceiver_skp_inserter_async_reset (
    input  logic clk,
    input  logic arst_n,
    output logic rst_n
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign rst_n = sync_reg[1];

endmodule

// File: rtl/transceiver_skp_inserter.sv
// TX clock-compensation SKP inserter, between framing logic and 8b/10b encoder.
// Forwards upstream symbols with one cycle of latency, fills idle cycles with
// SKP, and emits a scheduled burst of SKP_COUNT SKPs every SKP_INTERVAL cycles.
//   i_clk    : TX symbol clock
//   i_arst_n : asynchronous active-low reset (synchronised internally)
//   i_en     : enable scheduled bursts; 0 holds the interval counter at 0
//   i_valid  : upstream symbol valid
//   o_ready  : upstream may transfer this cycle (register-driven)
//   i_data   : upstream symbol {k, byte}
//   o_data   : symbol to encoder, valid every cycle
//   o_is_skp : o_data is a SKP (fill, burst, or forwarded)
//   o_burst  : o_data is a scheduled-burst SKP
module transceiver_skp_inserter
    import transceiver_skp_inserter_pkg::*;
#(
    parameter int DATA_WIDTH   = 9,
    parameter int SKP_INTERVAL = 1024,
    parameter int SKP_COUNT    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_is_skp,
    output logic                  o_burst
);

    localparam int CNT_WIDTH = $clog2(SKP_INTERVAL);
    localparam logic [CNT_WIDTH-1:0]  INT_LAST   = CNT_WIDTH'(SKP_INTERVAL - 1);
    localparam logic [CNT_WIDTH-1:0]  BURST_LAST = CNT_WIDTH'(SKP_COUNT - 1);
    localparam logic [DATA_WIDTH-1:0] SKP        = DATA_WIDTH'(SKP_SYMBOL);

    logic rst_n;

    transceiver_skp_inserter_async_reset u_rst_sync (
        .clk    (i_clk),
        .arst_n (i_arst_n),
        .rst_n  (rst_n)
    );

    state_t                 state_reg,     state_next;
    logic [CNT_WIDTH-1:0]   int_cnt_reg,   int_cnt_next;
    logic [CNT_WIDTH-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [DATA_WIDTH-1:0]  data_reg,      data_next;
    logic                   is_skp_reg,    is_skp_next;
    logic                   burst_reg,     burst_next;
    logic                   wrap;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_DATA;
            int_cnt_reg   <= '0;
            burst_cnt_reg <= '0;
            data_reg      <= SKP;
            is_skp_reg    <= 1'b1;
            burst_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            int_cnt_reg   <= int_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            data_reg      <= data_next;
            is_skp_reg    <= is_skp_next;
            burst_reg     <= burst_next;
        end
    end

    // The interval counter runs through bursts too, so burst starts stay
    // exactly SKP_INTERVAL cycles apart independent of traffic.
    assign wrap = i_en && (int_cnt_reg == INT_LAST);

    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        data_next      = SKP;
        is_skp_next    = 1'b1;
        burst_next     = 1'b0;

        if (!i_en || wrap) begin
            int_cnt_next = '0;
        end else begin
            int_cnt_next = int_cnt_reg + CNT_WIDTH'(1);
        end

        case (state_reg)
            ST_DATA: begin
                // o_ready is high here, so a valid symbol transfers even on
                // the wrap cycle; the burst follows it.
                if (i_valid) begin
                    data_next   = i_data;
                    is_skp_next = (i_data == SKP);
                end
                if (wrap) begin
                    state_next     = ST_SKP;
                    burst_cnt_next = '0;
                end
            end
            ST_SKP: begin
                burst_next     = 1'b1;
                burst_cnt_next = burst_cnt_reg + CNT_WIDTH'(1);
                if (burst_cnt_reg == BURST_LAST) begin
                    state_next = ST_DATA;
                end
            end
            default: begin
                state_next = ST_DATA;
            end
        endcase
    end

    assign o_ready  = (state_reg == ST_DATA);
    assign o_data   = data_reg;
    assign o_is_skp = is_skp_reg;
    assign o_burst  = burst_reg;

endmodule

// File: tb/tb_transceiver_skp_inserter.sv
// Scoreboard bench for transceiver_skp_inserter (SKP_INTERVAL=16, SKP_COUNT=2).
// The driver issues one input vector per cycle and pushes the expected
// post-edge outputs; the monitor pops and compares one entry per cycle.
module tb_transceiver_skp_inserter;

    localparam int         INTERVAL = 16;
    localparam int         COUNT    = 2;
    localparam logic [8:0] SKP      = 9'h17c;

    logic       clk = 1'b0;
    logic       i_arst_n = 1'b0;
    logic       i_en = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [8:0] i_data = 9'h000;
    logic [8:0] o_data;
    logic       o_is_skp;
    logic       o_burst;

    transceiver_skp_inserter #(
        .DATA_WIDTH   (9),
        .SKP_INTERVAL (INTERVAL),
        .SKP_COUNT    (COUNT)
    ) dut (
        .i_clk    (clk),
        .i_arst_n (i_arst_n),
        .i_en     (i_en),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_is_skp (o_is_skp),
        .o_burst  (o_burst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] data;
        logic       is_skp;
        logic       burst;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: edge index since reset release, edge at which the current
    // enable run began, SKPs still owed by a triggered burst, stream index.
    int p = 0;
    int en_start = -1;
    int burst_left = 0;
    int k = 0;
    int txn = 0;

    function automatic logic [8:0] data_of(input int idx);
        logic [31:0] v;
        v = idx;
        return (idx == 20) ? SKP : v[8:0];
    endfunction

    task automatic check_val(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, req);
        end
    endtask

    task automatic step(input bit v, input bit en, input bit rst_low);
        exp_t e;
        @(negedge clk);
        i_arst_n = rst_low ? 1'b0 : 1'b1;
        i_en     = en;
        i_valid  = v;
        i_data   = data_of(k);
        e = '{data: SKP, is_skp: 1'b1, burst: 1'b0, ready: 1'b1};
        if (rst_low) begin
            p = 0;
            en_start = -1;
            burst_left = 0;
        end else begin
            p++;
            // The first two edges after release are still inside the reset synchroniser.
            if (p >= 3) begin
                if (burst_left > 0) begin
                    e.burst = 1'b1;
                    burst_left--;
                end else if (v) begin
                    e.data   = data_of(k);
                    e.is_skp = (data_of(k) == SKP);
                    k++;
                end
                if (en) begin
                    if (en_start < 0) en_start = p;
                    else if ((p - en_start) % INTERVAL == INTERVAL - 1) burst_left = COUNT;
                end else begin
                    en_start = -1;
                end
                e.ready = (burst_left == 0);
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one output symbol per cycle, compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: o_data=%h is_skp=%0b burst=%0b ready=%0b", txn, o_data, o_is_skp, o_burst, o_ready);
                check_val("o_data",   o_data,          e.data);
                check_val("o_is_skp", {8'h0, o_is_skp}, {8'h0, e.is_skp});
                check_val("o_burst",  {8'h0, o_burst},  {8'h0, e.burst});
                check_val("o_ready",  {8'h0, o_ready},  {8'h0, e.ready});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset, then 42 idle cycles: bursts on edges 19,20 and 35,36 after release.
        repeat (3) step(0, 1, 1);
        repeat (42) step(0, 1, 0);
        // Continuous stream; index 20 carries a SKP value as data.
        repeat (60) step(1, 1, 0);
        // Enable off: no bursts; then reassert.
        repeat (50) step(1, 0, 0);
        repeat (40) step(1, 1, 0);
        // Deassert enable just as a burst starts: it still completes.
        n = 0;
        while (burst_left != COUNT && n < 40) begin
            step(1, 1, 0);
            n++;
        end
        repeat (20) step(1, 0, 0);
        repeat (20) step(1, 1, 0);
        // Reset while the first burst SKP is on the line.
        n = 0;
        while (burst_left != 1 && n < 40) begin
            step(1, 1, 0);
            n++;
        end
        @(posedge clk);
        #2;
        i_arst_n = 1'b0;
        #1;
        check_val("rst_mid_data",   o_data,           SKP);
        check_val("rst_mid_is_skp", {8'h0, o_is_skp}, 9'h001);
        check_val("rst_mid_burst",  {8'h0, o_burst},  9'h000);
        check_val("rst_mid_ready",  {8'h0, o_ready},  9'h001);
        repeat (3) step(0, 1, 1);
        repeat (3) step(0, 1, 0);
        repeat (40) step(1, 1, 0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
